// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the three-port RAM arbiter.
// Port numbering matches the core's requesters: fetch, load/store, I/O reader.
package tron_mem_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int PW   = 2;

    localparam logic [PW-1:0] PORT_FETCH = 2'd0;
    localparam logic [PW-1:0] PORT_DATA  = 2'd1;
    localparam logic [PW-1:0] PORT_IO    = 2'd2;
    localparam logic [PW-1:0] NO_OWNER   = 2'd3;

    typedef enum logic {
        IDLE,
        LOCKED
    } arbStateT;

    // Successor of a port index, wrapping at NREQ.
    function automatic logic [PW-1:0] nextPort(input logic [PW-1:0] p);
        return (p >= PW'(NREQ - 1)) ? '0 : p + PW'(1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-port commands in, grants and read returns out.
// The master modport is the requester side, slave is the arbiter.
interface mem_port_arbiter_if;
    import tron_mem_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    wrEn;
    logic [NREQ*AW-1:0] addrIn;
    logic [NREQ*DW-1:0] dataIn;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rdValid;
    logic [DW-1:0]      rdData;
    logic [PW-1:0]      lockOwner;

    modport master (
        output req, lock, wrEn, addrIn, dataIn,
        input  gnt, rdValid, rdData, lockOwner
    );

    modport slave (
        input  req, lock, wrEn, addrIn, dataIn,
        output gnt, rdValid, rdData, lockOwner
    );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first requesting port at or after rrPtr,
// wrapping modulo NREQ. Returns a one-hot winner (zero if nobody asks) and its index.
module rr_picker
    import tron_mem_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rrPtr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   winnerIdx
);

    logic [PW-1:0] candIdx [NREQ];
    logic          found;

    // candIdx[k] is the port examined k steps after rrPtr.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : gCand
            logic [PW:0] sum;
            assign sum          = {1'b0, rrPtr} + (PW+1)'(gi);
            assign candIdx[gi]  = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                          : sum[PW-1:0];
        end
    endgenerate

    always_comb begin
        winner    = '0;
        winnerIdx = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[candIdx[k]]) begin
                found              = 1'b1;
                winner[candIdx[k]] = 1'b1;
                winnerIdx          = candIdx[k];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data RAM between fetch, load/store and I/O readers.
// Round-robin with an optional bounded bus lock; read data returns two cycles after accept.
module mem_port_arbiter
    import tron_mem_pkg::*;
#(
    parameter int LOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic              memEn,
    output logic              memWe,
    output logic [AW-1:0]     memAddr,
    output logic [DW-1:0]     memWdata,
    input  logic [DW-1:0]     memRdata
);

    localparam int CW      = $clog2(LOCK_MAX + 1);
    localparam bit LOCK_EN = (LOCK_MAX > 1);

    arbStateT        stateReg;
    logic [PW-1:0]   rrPtrReg;
    logic [PW-1:0]   ownerReg;
    logic [CW-1:0]   lockCntReg;
    logic            tagValidReg;
    logic [PW-1:0]   tagPortReg;
    logic [NREQ-1:0] rdValidReg;

    logic [NREQ-1:0] pickOneHot;
    logic [PW-1:0]   pickIdx;
    logic [NREQ-1:0] ownerOneHot;
    logic [NREQ-1:0] selOneHot;
    logic [PW-1:0]   selIdx;
    logic [NREQ-1:0] gntNow;
    logic            accept;
    logic            selWr;
    logic            selLock;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    logic            lockRelease;

    rr_picker uPicker (
        .req       (bus.req),
        .rrPtr     (rrPtrReg),
        .winner    (pickOneHot),
        .winnerIdx (pickIdx)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : gOwner
            assign ownerOneHot[gi] = (ownerReg == PW'(gi));
        end
    endgenerate

    // While locked, the owner's fields are selected even when it is not requesting,
    // so its lock bit can decide whether the bus is released.
    always_comb begin
        if (stateReg == LOCKED) begin
            selOneHot = ownerOneHot;
            selIdx    = ownerReg;
        end else begin
            selOneHot = pickOneHot;
            selIdx    = pickIdx;
        end
        gntNow = reset ? '0 : (selOneHot & bus.req);
        accept = |gntNow;
    end

    always_comb begin
        selWr   = 1'b0;
        selLock = 1'b0;
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (selOneHot[i]) begin
                selWr   = bus.wrEn[i];
                selLock = bus.lock[i];
                selAddr = bus.addrIn[i*AW +: AW];
                selData = bus.dataIn[i*DW +: DW];
            end
        end
    end

    // lockCntReg counts locked grants already made; the LOCK_MAX-th one is the last.
    always_comb begin
        if (accept) begin
            lockRelease = !selLock || (lockCntReg == CW'(LOCK_MAX - 1));
        end else begin
            lockRelease = !selLock;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            rrPtrReg    <= '0;
            ownerReg    <= NO_OWNER;
            lockCntReg  <= '0;
            memEn       <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            tagValidReg <= 1'b0;
            tagPortReg  <= '0;
            rdValidReg  <= '0;
        end else begin
            memEn       <= accept;
            memWe       <= accept & selWr;
            tagValidReg <= accept & ~selWr;
            tagPortReg  <= selIdx;
            if (accept) begin
                memAddr  <= selAddr;
                memWdata <= selData;
                rrPtrReg <= nextPort(selIdx);
            end
            for (int i = 0; i < NREQ; i++) begin
                rdValidReg[i] <= tagValidReg && (tagPortReg == PW'(i));
            end

            case (stateReg)
                IDLE: begin
                    if (accept && selLock && LOCK_EN) begin
                        stateReg   <= LOCKED;
                        ownerReg   <= selIdx;
                        lockCntReg <= CW'(1);
                    end
                end
                LOCKED: begin
                    if (lockRelease) begin
                        stateReg   <= IDLE;
                        ownerReg   <= NO_OWNER;
                        lockCntReg <= '0;
                    end else if (accept) begin
                        lockCntReg <= lockCntReg + CW'(1);
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gntNow;
    assign bus.rdValid   = rdValidReg;
    assign bus.rdData    = (|rdValidReg) ? memRdata : '0;
    assign bus.lockOwner = ownerReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked against a behavioural arbitration/memory model.
module tb_mem_port_arbiter;
    import tron_mem_pkg::*;

    localparam int LOCK_MAX = 15;

    logic          clk;
    logic          reset;
    logic          memEn;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .memEn    (memEn),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memRdata (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM in the environment: registered read, write on enable.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) ram[memAddr] <= memWdata;
            else       memRdata <= ram[memAddr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmdT;

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rdT;

    cmdT cmdQ[$];
    rdT  rdQ[$];

    int tests = 0;
    int fails = 0;

    // Reference model: memory contents plus arbitration state in plain integers.
    logic [DW-1:0] shadow [0:65535];
    int mRr    = 0;
    int mOwner = 3;
    int mCnt   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic setPort(input int p, input logic r, input logic l, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[p]              = r;
        bus.lock[p]             = l;
        bus.wrEn[p]             = w;
        bus.addrIn[p*AW +: AW]  = a;
        bus.dataIn[p*DW +: DW]  = d;
    endtask

    task automatic modelReset();
        mRr    = 0;
        mOwner = 3;
        mCnt   = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns the DUT grant.
    task automatic doCycle(output logic [NREQ-1:0] g);
        int            win;
        int            granted;
        logic [2:0]    expG;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        cmdT           c;
        rdT            r;
        #1;
        win = -1;
        if (mOwner == 3) begin
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && bus.req[(mRr + k) % NREQ]) win = (mRr + k) % NREQ;
            end
        end else if (bus.req[mOwner]) begin
            win = mOwner;
        end
        expG = 3'b000;
        if (win >= 0) expG[win] = 1'b1;
        g = bus.gnt;
        check("gnt", 32'(g), 32'(expG));
        check("lockOwner", 32'(bus.lockOwner), 32'(mOwner));
        if (win >= 0) begin
            a      = bus.addrIn[win*AW +: AW];
            d      = bus.dataIn[win*DW +: DW];
            c.due  = cyc + 1;
            c.we   = bus.wrEn[win];
            c.addr = a;
            c.data = d;
            cmdQ.push_back(c);
            if (bus.wrEn[win]) begin
                shadow[a] = d;
            end else begin
                r.due  = cyc + 2;
                r.port = win;
                r.data = shadow[a];
                rdQ.push_back(r);
            end
            mRr = (win + 1) % NREQ;
            if (mOwner == 3) begin
                if (bus.lock[win]) begin
                    mOwner = win;
                    mCnt   = 1;
                end
            end else begin
                granted = mCnt + 1;
                if (!bus.lock[win] || granted == LOCK_MAX) begin
                    mOwner = 3;
                    mCnt   = 0;
                end else begin
                    mCnt = granted;
                end
            end
        end else if (mOwner != 3 && !bus.lock[mOwner]) begin
            mOwner = 3;
            mCnt   = 0;
        end
        @(negedge clk);
    endtask

    // Monitor: compares RAM commands and read returns against the scoreboard queues.
    initial begin
        logic       expEn;
        logic       expRd;
        logic [2:0] expV;
        forever begin
            @(negedge clk);
            if (!reset) begin
                expEn = (cmdQ.size() > 0) && (cmdQ[0].due == cyc);
                check("memEn", 32'(memEn), 32'(expEn));
                if (expEn) begin
                    check("memWe", 32'(memWe), 32'(cmdQ[0].we));
                    check("memAddr", 32'(memAddr), 32'(cmdQ[0].addr));
                    if (cmdQ[0].we) check("memWdata", 32'(memWdata), 32'(cmdQ[0].data));
                    $display("[TB] cyc %0d cmd we=%0b addr=%h wdata=%h",
                             cyc, cmdQ[0].we, cmdQ[0].addr, cmdQ[0].data);
                    void'(cmdQ.pop_front());
                end else begin
                    check("memWeIdle", 32'(memWe), 32'd0);
                end
                expRd = (rdQ.size() > 0) && (rdQ[0].due == cyc);
                expV  = 3'b000;
                if (expRd) expV[rdQ[0].port] = 1'b1;
                check("rdValid", 32'(bus.rdValid), 32'(expV));
                if (expRd) begin
                    check("rdData", 32'(bus.rdData), 32'(rdQ[0].data));
                    $display("[TB] cyc %0d read port=%0d data=%h", cyc, rdQ[0].port, bus.rdData);
                    void'(rdQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] rrExp [4];
        logic [NREQ-1:0] pend;

        rrExp[0] = 3'b001;
        rrExp[1] = 3'b010;
        rrExp[2] = 3'b100;
        rrExp[3] = 3'b001;

        reset      = 1'b0;
        bus.req    = '0;
        bus.lock   = '0;
        bus.wrEn   = '0;
        bus.addrIn = '0;
        bus.dataIn = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = DW'(i * 7);
            shadow[i] = DW'(i * 7);
        end
        ram[16'h0010]    = 16'hBEEF;
        shadow[16'h0010] = 16'hBEEF;

        // Reset values, with every port requesting so gnt gating is exercised.
        #1 reset = 1'b1;
        bus.req = 3'b111;
        #2;
        check("rstGnt", 32'(bus.gnt), 32'd0);
        check("rstRdValid", 32'(bus.rdValid), 32'd0);
        check("rstRdData", 32'(bus.rdData), 32'd0);
        check("rstMemEn", 32'(memEn), 32'd0);
        check("rstMemWe", 32'(memWe), 32'd0);
        check("rstMemAddr", 32'(memAddr), 32'd0);
        check("rstMemWdata", 32'(memWdata), 32'd0);
        check("rstLockOwner", 32'(bus.lockOwner), 32'd3);
        @(negedge clk);
        @(negedge clk);
        bus.req = '0;
        reset   = 1'b0;
        modelReset();

        // Single read of 0xBEEF by port 0.
        setPort(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        doCycle(g);
        check("singleGnt", 32'(g), 32'b001);
        setPort(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        doCycle(g);
        check("singleRdValid", 32'(bus.rdValid), 32'b001);
        check("singleRdData", 32'(bus.rdData), 32'hBEEF);
        doCycle(g);
        doCycle(g);

        // Write 0x1234 to 0x20 from port 1, then read it back on port 2.
        setPort(1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h1234);
        doCycle(g);
        check("wrGnt", 32'(g), 32'b010);
        setPort(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        setPort(2, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        doCycle(g);
        check("rdAfterWrGnt", 32'(g), 32'b100);
        setPort(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        doCycle(g);
        check("rdAfterWrData", 32'(bus.rdData), 32'h1234);
        doCycle(g);

        // Reset one cycle after a port 0 read accept.
        setPort(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        doCycle(g);
        check("midRstGnt", 32'(g), 32'b001);
        setPort(0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 reset = 1'b1;
        #1;
        check("midRstMemEn", 32'(memEn), 32'd0);
        check("midRstMemAddr", 32'(memAddr), 32'd0);
        check("midRstRdValid", 32'(bus.rdValid), 32'd0);
        check("midRstLockOwner", 32'(bus.lockOwner), 32'd3);
        cmdQ.delete();
        rdQ.delete();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Round-robin with all three held from reset.
        setPort(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        setPort(1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        setPort(2, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            doCycle(g);
            check("rrOrder", 32'(g), 32'(rrExp[i]));
        end
        bus.req = '0;
        doCycle(g);
        doCycle(g);
        doCycle(g);

        // Lock by port 1 for three accesses while ports 0 and 2 wait.
        setPort(0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
        setPort(2, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000);
        setPort(1, 1'b1, 1'b1, 1'b1, 16'h0040, 16'hA001);
        doCycle(g);
        check("lockGnt1", 32'(g), 32'b010);
        check("lockOwnerHeld", 32'(bus.lockOwner), 32'd1);
        setPort(1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        doCycle(g);
        check("lockGnt2", 32'(g), 32'b010);
        setPort(1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hA003);
        doCycle(g);
        check("lockGnt3", 32'(g), 32'b010);
        setPort(1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        doCycle(g);
        check("afterLockGnt", 32'(g), 32'b100);
        setPort(2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        doCycle(g);
        check("afterLockGnt0", 32'(g), 32'b001);
        bus.req = '0;
        doCycle(g);
        doCycle(g);

        // Lock timeout: port 1 never lets go.
        setPort(0, 1'b1, 1'b0, 1'b0, 16'h0013, 16'h0000);
        setPort(1, 1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000);
        setPort(2, 1'b1, 1'b0, 1'b0, 16'h0014, 16'h0000);
        for (int i = 0; i < 17; i++) begin
            if (i == 15) check("timeoutLockOwner", 32'(bus.lockOwner), 32'd3);
            doCycle(g);
            if (i < 15)       check("timeoutHold", 32'(g), 32'b010);
            else if (i == 15) check("timeoutNext", 32'(g), 32'b100);
        end
        bus.req  = '0;
        bus.lock = '0;
        doCycle(g);
        doCycle(g);
        doCycle(g);

        // Random traffic; requesters hold until granted.
        pend = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 99) < 45) begin
                        pend[p] = 1'b1;
                        setPort(p, 1'b1,
                                ($urandom_range(0, 99) < ((p == 1) ? 40 : 10)),
                                1'($urandom_range(0, 1)),
                                AW'($urandom_range(0, 31)), DW'($urandom));
                    end else begin
                        setPort(p, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                AW'($urandom), DW'($urandom));
                    end
                end
            end
            doCycle(g);
            pend = pend & ~g;
        end
        bus.req  = '0;
        bus.lock = '0;
        for (int i = 0; i < 4; i++) doCycle(g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
